// File: rtl/noc_rx_endpoint_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_rx_endpoint_pkg: static link parameters shared by the RX endpoint.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package noc_rx_endpoint_pkg;

  // Values mirror the platform's static_params.vh build settings.
  localparam int SP_DATAW          = 64;
  localparam int SP_AXIS_MAX_DATAW = 64;
  localparam int SP_AXIS_DESTW     = 4;
  localparam int SP_AXIS_IDW       = 4;
  localparam int SP_FIFO_DEPTH     = 4;

endpackage
`default_nettype wire

// File: rtl/add_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_fifo: show-ahead synchronous FIFO, head entry visible on r_data.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module add_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  always_ff @(posedge clk) begin
    if (w_enable) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (w_enable) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (r_enable) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      end
      case ({w_enable, r_enable})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign r_data = mem[rd_ptr];
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);

endmodule
`default_nettype wire

// File: rtl/noc_rx_endpoint.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_rx_endpoint: filters NoC AXIS packets by tdest and buffers them.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module noc_rx_endpoint
  import noc_rx_endpoint_pkg::*;
#(
  parameter int                     DATA_W     = SP_DATAW,
  parameter int                     FIFO_DEPTH = SP_FIFO_DEPTH,
  parameter logic [SP_AXIS_DESTW-1:0] MY_ADDR  = '0,
  parameter int                     CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axis_rx_tvalid,
  output logic                         axis_rx_tready,
  input  logic [SP_AXIS_MAX_DATAW-1:0] axis_rx_tdata,
  input  logic                         axis_rx_tlast,
  input  logic [SP_AXIS_DESTW-1:0]     axis_rx_tdest,
  input  logic [SP_AXIS_IDW-1:0]       axis_rx_tid,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [DATA_W-1:0]            rx_tdata,
  output logic                         rx_tlast,
  output logic [CNT_W-1:0]             pkt_count,
  output logic [CNT_W-1:0]             drop_count,
  output logic                         busy
);

  localparam logic [1:0] ST_HEAD = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef enum logic [1:0] {
    HEAD = ST_HEAD,
    BODY = ST_BODY,
    DROP = ST_DROP
  } state_t;

  state_t            state, state_nxt;
  logic              accept, hit, push, pop, drop_inc, pkt_inc;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic              unused_bits;

  // tid and any tdata bits above DATA_W carry nothing for this endpoint.
  assign unused_bits = ^{axis_rx_tid, axis_rx_tdata};

  assign axis_rx_tready = (state == DROP) ? 1'b1 : ~fifo_full;
  assign accept         = axis_rx_tvalid & axis_rx_tready;
  assign hit            = (axis_rx_tdest == MY_ADDR);
  assign pop            = ~fifo_empty & rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HEAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop_inc  = 1'b0;
    if (accept) begin
      case (state)
        HEAD: begin
          if (hit) begin
            push = 1'b1;
            if (!axis_rx_tlast) state_nxt = BODY;
          end else if (axis_rx_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_nxt = DROP;
          end
        end
        BODY: begin
          push = 1'b1;
          if (axis_rx_tlast) state_nxt = HEAD;
        end
        DROP: begin
          if (axis_rx_tlast) begin
            drop_inc  = 1'b1;
            state_nxt = HEAD;
          end
        end
        default: state_nxt = HEAD;
      endcase
    end
  end

  add_fifo #(
    .DATA_WIDTH (DATA_W + 1),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_enable (push),
    .w_data   ({axis_rx_tlast, axis_rx_tdata[DATA_W-1:0]}),
    .r_enable (pop),
    .r_data   (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_tdata = fifo_rdata[DATA_W-1:0];
  assign rx_tlast = fifo_rdata[DATA_W];
  assign pkt_inc  = pop & rx_tlast;
  assign busy     = (state != HEAD) | ~fifo_empty;

  // Counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pkt_inc && (pkt_count != '1))   pkt_count  <= pkt_count + CNT_W'(1);
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_rx_endpoint.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_noc_rx_endpoint: directed self-checking bench for noc_rx_endpoint.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_noc_rx_endpoint;
  import noc_rx_endpoint_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic                         axis_rx_tvalid;
  logic                         axis_rx_tready;
  logic [SP_AXIS_MAX_DATAW-1:0] axis_rx_tdata;
  logic                         axis_rx_tlast;
  logic [SP_AXIS_DESTW-1:0]     axis_rx_tdest;
  logic [SP_AXIS_IDW-1:0]       axis_rx_tid;
  logic                         rx_valid;
  logic                         rx_ready;
  logic [63:0]                  rx_tdata;
  logic                         rx_tlast;
  logic [15:0]                  pkt_count;
  logic [15:0]                  drop_count;
  logic                         busy;

  int n_checks = 0;
  int n_fail   = 0;

  noc_rx_endpoint #(
    .DATA_W     (64),
    .FIFO_DEPTH (4),
    .MY_ADDR    ('0),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axis_rx_tvalid (axis_rx_tvalid),
    .axis_rx_tready (axis_rx_tready),
    .axis_rx_tdata  (axis_rx_tdata),
    .axis_rx_tlast  (axis_rx_tlast),
    .axis_rx_tdest  (axis_rx_tdest),
    .axis_rx_tid    (axis_rx_tid),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_tdata       (rx_tdata),
    .rx_tlast       (rx_tlast),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] data, input logic [3:0] dest,
                       input logic last);
    axis_rx_tvalid = 1'b1;
    axis_rx_tdata  = data;
    axis_rx_tdest  = dest;
    axis_rx_tlast  = last;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    axis_rx_tvalid = 1'b0;
    rx_ready       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_ready = 1'b0; axis_rx_tid = 4'h5;
    drive(64'h99, 4'h0, 1'b0);
    step();
    step();
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tready", axis_rx_tready, 1);
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_drop_count", drop_count, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1; axis_rx_tvalid = 1'b0;
    step();
    check_eq("rst_no_push", rx_valid, 0);

    // Three-beat packet to this endpoint.
    rx_ready = 1'b1;
    drive(64'd10, 4'h0, 1'b0); step();
    check_eq("dlv_b0_valid", rx_valid, 1);
    check_eq("dlv_b0_data", rx_tdata, 10);
    check_eq("dlv_b0_last", rx_tlast, 0);
    drive(64'd11, 4'h0, 1'b0); step();
    check_eq("dlv_b1_data", rx_tdata, 11);
    check_eq("dlv_b1_last", rx_tlast, 0);
    drive(64'd12, 4'h0, 1'b1); step();
    check_eq("dlv_b2_data", rx_tdata, 12);
    check_eq("dlv_b2_last", rx_tlast, 1);
    axis_rx_tvalid = 1'b0; step();
    check_eq("dlv_drained", rx_valid, 0);
    check_eq("dlv_pkt_count", pkt_count, 1);
    check_eq("dlv_busy", busy, 0);

    // Foreign packet discarded, following local one delivered.
    do_reset();
    rx_ready = 1'b1;
    drive(64'd5, 4'h1, 1'b0);
    check_eq("drop_tready_head", axis_rx_tready, 1);
    step();
    check_eq("drop_tready_mid", axis_rx_tready, 1);
    check_eq("drop_busy_mid", busy, 1);
    check_eq("drop_b0_nopush", rx_valid, 0);
    drive(64'd6, 4'h1, 1'b1); step();
    check_eq("drop_b1_nopush", rx_valid, 0);
    check_eq("drop_count", drop_count, 1);
    check_eq("drop_tready_after", axis_rx_tready, 1);
    drive(64'd7, 4'h0, 1'b1); step();
    check_eq("drop_keep_data", rx_tdata, 7);
    check_eq("drop_keep_last", rx_tlast, 1);
    axis_rx_tvalid = 1'b0; step();
    check_eq("drop_pkt_count", pkt_count, 1);
    check_eq("drop_count_final", drop_count, 1);

    // Backpressure, full with simultaneous pop, push+pop ordering.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(64'(i), 4'h0, 1'b0);
      check_eq("bp_tready_fill", axis_rx_tready, 1);
      step();
    end
    drive(64'd5, 4'h0, 1'b0);
    check_eq("bp_full_tready", axis_rx_tready, 0);
    check_eq("bp_full_head", rx_tdata, 1);
    check_eq("bp_full_busy", busy, 1);
    step();
    check_eq("bp_hold_tready", axis_rx_tready, 0);
    check_eq("bp_hold_head", rx_tdata, 1);
    rx_ready = 1'b1; step();
    check_eq("fp_pop_no_accept", axis_rx_tready, 1);
    check_eq("fp_head_2", rx_tdata, 2);
    rx_ready = 1'b0; step();
    check_eq("fp_refull_tready", axis_rx_tready, 0);
    check_eq("fp_refull_head", rx_tdata, 2);
    drive(64'd6, 4'h0, 1'b1);
    rx_ready = 1'b1; step();
    check_eq("fp_head_3", rx_tdata, 3);
    check_eq("fp_tready_3", axis_rx_tready, 1);
    step();
    axis_rx_tvalid = 1'b0;
    check_eq("fp_pushpop_head", rx_tdata, 4);
    check_eq("fp_pushpop_last", rx_tlast, 0);
    step();
    check_eq("bp_head_5", rx_tdata, 5);
    check_eq("bp_last_5", rx_tlast, 0);
    step();
    check_eq("bp_head_6", rx_tdata, 6);
    check_eq("bp_last_6", rx_tlast, 1);
    step();
    check_eq("bp_drained", rx_valid, 0);
    check_eq("bp_pkt_count", pkt_count, 1);

    // Reset in the middle of a kept packet.
    do_reset();
    drive(64'h21, 4'h0, 1'b0); step();
    drive(64'h22, 4'h0, 1'b0); step();
    check_eq("mid_buffered", rx_valid, 1);
    rst_n = 1'b0; axis_rx_tvalid = 1'b0; step();
    rst_n = 1'b1;
    check_eq("mid_rst_empty", rx_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    rx_ready = 1'b1;
    drive(64'h30, 4'h1, 1'b1); step();
    check_eq("mid_head_drop", rx_valid, 0);
    check_eq("mid_drop_count", drop_count, 1);
    drive(64'h23, 4'h0, 1'b0); step();
    check_eq("mid_b0_data", rx_tdata, 64'h23);
    check_eq("mid_b0_last", rx_tlast, 0);
    drive(64'h24, 4'h0, 1'b1); step();
    check_eq("mid_b1_data", rx_tdata, 64'h24);
    check_eq("mid_b1_last", rx_tlast, 1);
    axis_rx_tvalid = 1'b0; step();
    check_eq("mid_pkt_count", pkt_count, 1);
    check_eq("mid_drained", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_rx_endpoint.md
Name: noc_rx_endpoint

Overview:
- Receive side of the NoC AXI-stream link; the counterpart of the transmitting client.
- Accepts AXIS beats from the NoC and keeps only packets whose tdest equals this endpoint's address. All other packets are discarded in full, up to and including tlast.
- Accepted beats are buffered, together with their tlast bit, in a FIFO. The FIFO is presented to the local consumer through a simple valid/ready/last stream.
- Packet-level delivered/dropped counters are kept for performance measurement.

Parameters:
- DATA_W, `DATAW: payload width delivered to the consumer; the low DATA_W bits of axis_rx_tdata are kept.
- FIFO_DEPTH, `FIFO_DEPTH: number of buffered beats.
- MY_ADDR, `AXIS_DESTW'b0: tdest value accepted by this endpoint.
- CNT_W, 16: width of the packet counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- axis_rx_tvalid  input  1  NoC beat valid
- axis_rx_tready  output  1  NoC beat ready
- axis_rx_tdata  input  `AXIS_MAX_DATAW  NoC beat data
- axis_rx_tlast  input  1  last beat of packet
- axis_rx_tdest  input  `AXIS_DESTW  destination address
- axis_rx_tid  input  `AXIS_IDW  source id; ignored
- rx_valid  output  1  beat available to consumer
- rx_ready  input  1  consumer accepts beat
- rx_tdata  output  DATA_W  beat data
- rx_tlast  output  1  beat is last of its packet
- pkt_count  output  CNT_W  packets fully delivered to consumer
- drop_count  output  CNT_W  packets discarded on address mismatch
- busy  output  1  state != HEAD or FIFO non-empty

Behaviour:
- Clock and reset: clk; rst_n is synchronous and active-low.
- Reset state:
  - state = HEAD, FIFO emptied, counters = 0.
  - rx_valid = 0, busy = 0, axis_rx_tready = 1.
  - rx_tdata and rx_tlast are don't-care while rx_valid = 0.
- Handshake definitions:
  - NoC beat accepted when axis_rx_tvalid && axis_rx_tready.
  - Consumer pop when rx_valid && rx_ready.
- FSM states: HEAD (expecting the first beat of a packet), BODY (mid-packet, keeping), DROP (mid-packet, discarding).
- axis_rx_tready:
  - ~fifo_full in HEAD and BODY.
  - 1 in DROP.
  - Never depends on axis_rx_tvalid or axis_rx_tdest.
- HEAD, beat accepted:
  - tdest == MY_ADDR: push {tlast, tdata[DATA_W-1:0]}. Next state is HEAD if tlast, else BODY.
  - tdest != MY_ADDR: no push. If tlast, drop_count++ and stay in HEAD; else go to DROP.
- BODY, beat accepted: push; if tlast, go to HEAD. tdest of non-head beats is ignored.
- DROP, beat accepted: no push; if tlast, drop_count++ and go to HEAD.
- Output path:
  - Show-ahead FIFO: rx_valid = ~empty; rx_tdata and rx_tlast come from the head entry in the same cycle.
  - Latency: a beat accepted at edge N is visible on rx_* after edge N, i.e. one cycle, when the FIFO was empty.
- pkt_count increments on each consumer pop with rx_tlast = 1.
- Counters saturate at all-ones and do not wrap.
- FIFO full:
  - tready = 0 in HEAD/BODY, even if a pop occurs in the same cycle; there is no full-bypass.
  - A pop frees the entry for the next cycle.
- FIFO empty: a push and no pop makes rx_valid 1 on the next cycle. There is no write-to-read bypass.
- Simultaneous push and pop: occupancy is unchanged and order is preserved.
- Beats with axis_rx_tvalid = 0 never change state or counters.
- Reset mid-packet:
  - All buffered beats are lost and counters are cleared.
  - The next NoC beat is treated as a packet head and its tdest is evaluated.
  - Upstream is responsible for resetting together with this endpoint.
- Sub-module contract: the FIFO must never see w_enable on full or r_enable on empty.

Decomposition:
- static_params.vh supplies DATAW, AXIS_MAX_DATAW, AXIS_DESTW, AXIS_IDW and FIFO_DEPTH.
- A 2-bit state encoding (HEAD = 0, BODY = 1, DROP = 2) is defined as localparams in the module.
- One sub-module: the existing add_fifo, instantiated with DATA_WIDTH = DATA_W + 1; the MSB holds tlast.

Test Plan (DATA_W = 64, FIFO_DEPTH = 4, MY_ADDR = 0):
- Reset: hold rst_n = 0 for 2 cycles with tvalid = 1 -> rx_valid = 0, tready = 1, counts = 0, busy = 0, no push.
- Delivery: 3-beat packet, tdest = 0, data 10/11/12, rx_ready = 1 -> rx_tdata 10, 11, 12 on consecutive cycles one cycle after each accept; rx_tlast only with 12; pkt_count = 1.
- Drop: 2-beat packet with tdest = 1 (data 5, 6), then a 1-beat packet with tdest = 0 (data 7) -> tready stays 1 throughout; only 7 is delivered, with rx_tlast = 1; drop_count = 1, pkt_count = 1.
- Backpressure: rx_ready = 0 and a 6-beat packet (data 1..6, tdest = 0) -> 4 beats accepted, then tready = 0. Set rx_ready = 1 -> 1..6 delivered in order, tlast on 6, no beat lost or duplicated.
- Full plus pop: FIFO full, rx_ready = 1 and tvalid = 1 in the same cycle -> no accept that cycle, accept on the next; occupancy goes 4 -> 3 -> 4.
- Mid-packet reset: after 2 beats of a 4-beat tdest = 0 packet, assert reset for 1 cycle, then send the remaining beats with tdest = 0 -> FIFO empty after reset; the remaining beats are delivered as a new packet; pkt_count = 1 after their tlast.
